press_classifier: RTL

- Downstream consumer of the switch debouncer. Takes the debounced level and the rising-edge tick, then classifies each button gesture.
- Three gesture types: short press, long press, double click. Each is reported as a single-cycle event pulse to application logic (counters, mode selects, display control).
- A single timer is shared across all states. Thresholds are set in clock cycles (10 ns at 100 MHz).

---
 rtl/press_pkg.sv | 24 ++
 rtl/press_timer.sv | 28 ++
 rtl/press_classifier.sv | 134 +++++++++++++
 3 files changed

// File: rtl/press_pkg.sv
// Shared types and threshold constants for the button gesture classifier.
package press_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // Hardware thresholds at 100 MHz.
  localparam int DEF_CNT_W      = 27;
  localparam int DEF_LONG_CNT   = 100_000_000;
  localparam int DEF_DBL_CNT    = 30_000_000;
  localparam int DEF_REPEAT_CNT = 20_000_000;

  // Shrunk thresholds so gestures fit in a short simulation.
  localparam int SIM_CNT_W      = 5;
  localparam int SIM_LONG_CNT   = 16;
  localparam int SIM_DBL_CNT    = 8;
  localparam int SIM_REPEAT_CNT = 4;

endpackage

// File: rtl/press_timer.sv
// Shared gesture timer: clearable up-counter with a terminal-count compare
// against a limit chosen by the FSM each cycle.
module press_timer
  import press_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit - CNT_W'(1));

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short press, long press and
// double click pulses. Define PRESS_AUTOREPEAT_EN to repeat long_press while held.
module press_classifier
  import press_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int DBL_CNT    = DEF_DBL_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  input  logic db_tick,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CNT);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CNT);

  state_t           state;
  logic             tc;
  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] limit;

  // The timer restarts whenever the FSM leaves a timed state or sits in an untimed one.
  always_comb begin
    limit   = LONG_LIM;
    tmr_clr = 1'b1;
    case (state)
      PRESS1: begin
        limit   = LONG_LIM;
        tmr_clr = !db_level || tc;
      end
      GAP: begin
        limit   = DBL_LIM;
        tmr_clr = db_tick || tc;
      end
      HOLD: begin
        limit   = REP_LIM;
`ifdef PRESS_AUTOREPEAT_EN
        tmr_clr = !db_level || tc;
`else
        tmr_clr = 1'b1;
`endif
      end
      default: begin
        limit   = LONG_LIM;
        tmr_clr = 1'b1;
      end
    endcase
  end

  assign tmr_en = (state != IDLE);

  press_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (limit),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      case (state)
        IDLE: begin
          if (db_tick) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          if (!db_level) begin
            state <= GAP;
          end else if (tc) begin
            state      <= HOLD;
            long_press <= 1'b1;
          end
        end
        GAP: begin
          // A tick landing on the timeout cycle still counts as a double click.
          if (db_tick) begin
            state        <= PRESS2;
            double_click <= 1'b1;
          end else if (tc) begin
            state       <= IDLE;
            short_press <= 1'b1;
            busy        <= 1'b0;
          end
        end
        PRESS2: begin
          if (!db_level) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (!db_level) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`ifdef PRESS_AUTOREPEAT_EN
          else if (tc) begin
            long_press <= 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
